// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the MIPS-core memory wait controller.
package mem_ctrl_pkg;
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        RD_RESP  = 2'd2,
        WR_DRAIN = 2'd3
    } state_e;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;
    localparam int          WORD_BYTES   = 4;
    localparam int          OFS_W        = $clog2(WORD_BYTES);
endpackage

// File: rtl/mem_wait_ctrl_if.sv
// Core-side and memory-side bus of mem_wait_ctrl bundled as one interface.
// slave = the controller's view; master = the core plus memory that surround it.
interface mem_wait_ctrl_if #(parameter int ADDR_W = 6) ();
    logic              cpu_req;
    logic              cpu_we;
    logic [31:0]       cpu_adr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_ready;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_adr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport slave (
        input  cpu_req, cpu_we, cpu_adr, cpu_wdata, mem_rdata, mem_ack,
        output cpu_rdata, cpu_ready, mem_req, mem_we, mem_adr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_adr, cpu_wdata, mem_rdata, mem_ack,
        input  cpu_rdata, cpu_ready, mem_req, mem_we, mem_adr, mem_wdata
    );
endinterface

// File: rtl/mem_wbuf.sv
// One-entry posted-store buffer: holds word address and data until drained.
module mem_wbuf #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [ADDR_W-1:0] ld_adr,
    input  logic [31:0]       ld_data,
    input  logic [ADDR_W-1:0] cmp_adr,
    output logic              vld,
    output logic [31:0]       data,
    output logic              hit
);
    logic [ADDR_W-1:0] adr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld  <= 1'b0;
            adr  <= '0;
            data <= '0;
        end else if (load) begin
            vld  <= 1'b1;
            adr  <= ld_adr;
            data <= ld_data;
        end else if (clear) begin
            vld  <= 1'b0;
        end
    end

    assign hit = vld & (adr == cmp_adr);
endmodule

// File: rtl/mem_wait_ctrl.sv
// Core-to-memory wait controller with a posted store buffer, read forwarding and timeout.
// Optional build macro MEM_CTRL_STATS_EN adds the stall_cnt output.
module mem_wait_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    mem_wait_ctrl_if.slave  bus,
    output logic            err
`ifdef MEM_CTRL_STATS_EN
    ,
    output logic [31:0]     stall_cnt
`endif
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_adr_q, mem_adr_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    logic              ready_c, cpu_ready_o;
    logic [31:0]       rdata_c;
    logic              wb_load, wb_clear, wb_vld, wb_hit;
    logic [31:0]       wb_data;
    logic [ADDR_W-1:0] cpu_word;
    logic              misal, waiting, tmo;
    logic              unused_adr;

    assign cpu_word   = bus.cpu_adr[ADDR_W+OFS_W-1:OFS_W];
    assign misal      = |bus.cpu_adr[OFS_W-1:0];
    assign unused_adr = ^bus.cpu_adr[31:ADDR_W+OFS_W];
    assign waiting    = (state_q == RD_WAIT) | (state_q == WR_DRAIN);
    // An ack in the terminal-count cycle suppresses the abort.
    assign tmo        = waiting & ~bus.mem_ack & (cnt_q == CNT_W'(TIMEOUT - 1));

    mem_wbuf #(.ADDR_W(ADDR_W)) u_wbuf (
        .clk     (clk),
        .reset   (reset),
        .load    (wb_load),
        .clear   (wb_clear),
        .ld_adr  (cpu_word),
        .ld_data (bus.cpu_wdata),
        .cmp_adr (cpu_word),
        .vld     (wb_vld),
        .data    (wb_data),
        .hit     (wb_hit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_adr_q <= '0;
            rdata_q   <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_req_q <= mem_req_d;
            mem_we_q  <= mem_we_d;
            mem_adr_q <= mem_adr_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_req_d = mem_req_q;
        mem_we_d  = mem_we_q;
        mem_adr_d = mem_adr_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q + CNT_W'(1);
        err_d     = err_q;
        ready_c   = 1'b0;
        rdata_c   = '0;
        wb_load   = 1'b0;
        wb_clear  = 1'b0;

        // Misaligned accesses complete at once with no memory traffic.
        if (bus.cpu_req & misal & ((state_q == IDLE) | (state_q == WR_DRAIN))) begin
            ready_c = 1'b1;
            err_d   = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.cpu_req & ~misal) begin
                    if (!bus.cpu_we) begin
                        mem_req_d = 1'b1;
                        mem_we_d  = 1'b0;
                        mem_adr_d = cpu_word;
                        cnt_d     = '0;
                        state_d   = RD_WAIT;
                    end else if (!wb_vld) begin
                        ready_c   = 1'b1;
                        wb_load   = 1'b1;
                        mem_req_d = 1'b1;
                        mem_we_d  = 1'b1;
                        mem_adr_d = cpu_word;
                        cnt_d     = '0;
                        state_d   = WR_DRAIN;
                    end
                end
            end
            RD_WAIT: begin
                if (bus.mem_ack | tmo) begin
                    mem_req_d = 1'b0;
                    rdata_d   = bus.mem_ack ? bus.mem_rdata : TIMEOUT_DATA;
                    err_d     = err_d | tmo;
                    state_d   = RD_RESP;
                end
            end
            RD_RESP: begin
                ready_c = 1'b1;
                rdata_c = rdata_q;
                state_d = IDLE;
            end
            WR_DRAIN: begin
                if (bus.cpu_req & ~misal & ~bus.cpu_we & wb_hit) begin
                    ready_c = 1'b1;
                    rdata_c = wb_data;
                end
                // Stores and read misses wait here; they are re-decoded from IDLE.
                if (bus.mem_ack | tmo) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    wb_clear  = 1'b1;
                    err_d     = err_d | tmo;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cpu_ready_o   = reset & ready_c;
    assign bus.cpu_ready = cpu_ready_o;
    assign bus.cpu_rdata = rdata_c;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_adr   = mem_adr_q;
    assign bus.mem_wdata = wb_data;
    assign err           = err_q;

`ifdef MEM_CTRL_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cnt <= '0;
        else if (bus.cpu_req & ~cpu_ready_o & ~&stall_cnt)
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif
endmodule
